// File: rtl/video_stream_checker.sv
// video_stream_checker: measures line/frame geometry of an fv/lv qualified
// pixel stream and flags width, height, data-ramp and lv-outside-fv errors.
module video_stream_checker #(
  parameter int EXP_WIDTH  = 1920,
  parameter int EXP_HEIGHT = 1080,
  parameter int CHECK_DATA = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [9:0]  data,
  input  logic        fv,
  input  logic        lv,
  input  logic        clr_err,
  output logic [15:0] frame_width,
  output logic [15:0] frame_height,
  output logic [15:0] frame_count,
  output logic        frame_done,
  output logic        err_width,
  output logic        err_height,
  output logic        err_data,
  output logic        err_lv
);

  localparam logic [15:0] EW = 16'(EXP_WIDTH);
  localparam logic [15:0] EH = 16'(EXP_HEIGHT);

  typedef enum logic [1:0] {SYNC, WAIT_FV, IN_FRAME} state_t;

  state_t      state;
  logic        fv_d, lv_d;
  logic [15:0] pix_cnt, line_cnt;
  logic [9:0]  prev_data;
  logic        line_open;   // lv rise seen inside this frame for the current line

  logic        fv_rise, fv_fall, lv_rise, lv_fall, pix_on, in_frame;
  logic [15:0] pix_inc, line_inc, height_now;
  logic [9:0]  exp_pix;
  logic        w_evt, h_evt, d_evt, l_evt;

  assign fv_rise    = fv & ~fv_d;
  assign fv_fall    = ~fv & fv_d;
  assign lv_rise    = lv & ~lv_d;
  assign lv_fall    = ~lv & lv_d;
  assign pix_on     = fv & lv;
  assign in_frame   = (state == IN_FRAME);
  assign pix_inc    = (pix_cnt  == 16'hFFFF) ? pix_cnt  : pix_cnt  + 16'd1;
  assign line_inc   = (line_cnt == 16'hFFFF) ? line_cnt : line_cnt + 16'd1;
  // a line closing on the same edge as the frame still counts toward height
  assign height_now = lv_fall ? line_inc : line_cnt;
  assign exp_pix    = lv_rise ? 10'd0 : prev_data + 10'd1;

  // error events for this cycle
  always_comb begin
    w_evt = 1'b0;
    h_evt = 1'b0;
    d_evt = 1'b0;
    l_evt = lv & ~fv;
    if (in_frame) begin
      w_evt = lv_fall & (~line_open | (pix_cnt != EW));
      h_evt = fv_fall & (height_now != EH);
      d_evt = (CHECK_DATA != 0) & pix_on & (data != exp_pix);
    end
  end

  // frame tracking FSM, counters, measured geometry and sticky flags
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= SYNC;
      fv_d         <= 1'b0;
      lv_d         <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      prev_data    <= '0;
      line_open    <= 1'b0;
      frame_width  <= '0;
      frame_height <= '0;
      frame_count  <= '0;
      frame_done   <= 1'b0;
      err_width    <= 1'b0;
      err_height   <= 1'b0;
      err_data     <= 1'b0;
      err_lv       <= 1'b0;
    end else begin
      fv_d       <= fv;
      lv_d       <= lv;
      frame_done <= 1'b0;
      err_width  <= (err_width  & ~clr_err) | w_evt;
      err_height <= (err_height & ~clr_err) | h_evt;
      err_data   <= (err_data   & ~clr_err) | d_evt;
      err_lv     <= (err_lv     & ~clr_err) | l_evt;
      case (state)
        SYNC: begin
          if (!fv) state <= WAIT_FV;
        end
        WAIT_FV: begin
          if (fv_rise) begin
            state     <= IN_FRAME;
            pix_cnt   <= '0;
            line_cnt  <= '0;
            line_open <= 1'b0;
          end
        end
        IN_FRAME: begin
          if (pix_on) begin
            pix_cnt   <= pix_inc;
            prev_data <= data;
            if (lv_rise) line_open <= 1'b1;
          end
          if (lv_fall) begin
            frame_width <= line_open ? pix_cnt : 16'd0;
            line_cnt    <= line_inc;
            pix_cnt     <= '0;
            line_open   <= 1'b0;
          end
          if (fv_fall) begin
            frame_height <= height_now;
            frame_count  <= frame_count + 16'd1;
            frame_done   <= 1'b1;
            state        <= WAIT_FV;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Bench for video_stream_checker: three instances share one stream
// (20x6 with data check, 1030x2 for the ramp wrap, 20x6 without data check).
module tb_video_stream_checker;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, fv, lv, clr_err;
  logic [9:0] data;
  logic [15:0] fw0, fh0, fc0, fw1, fh1, fc1, fw2, fh2, fc2;
  logic fd0, ew0, eh0, ed0, el0, fd1, ew1, eh1, ed1, el1, fd2, ew2, eh2, ed2, el2;

  video_stream_checker #(.EXP_WIDTH(20), .EXP_HEIGHT(6), .CHECK_DATA(1)) u0 (
    .clk(clk), .rstn(rstn), .data(data), .fv(fv), .lv(lv), .clr_err(clr_err),
    .frame_width(fw0), .frame_height(fh0), .frame_count(fc0), .frame_done(fd0),
    .err_width(ew0), .err_height(eh0), .err_data(ed0), .err_lv(el0));
  video_stream_checker #(.EXP_WIDTH(1030), .EXP_HEIGHT(2), .CHECK_DATA(1)) u1 (
    .clk(clk), .rstn(rstn), .data(data), .fv(fv), .lv(lv), .clr_err(clr_err),
    .frame_width(fw1), .frame_height(fh1), .frame_count(fc1), .frame_done(fd1),
    .err_width(ew1), .err_height(eh1), .err_data(ed1), .err_lv(el1));
  video_stream_checker #(.EXP_WIDTH(20), .EXP_HEIGHT(6), .CHECK_DATA(0)) u2 (
    .clk(clk), .rstn(rstn), .data(data), .fv(fv), .lv(lv), .clr_err(clr_err),
    .frame_width(fw2), .frame_height(fh2), .frame_count(fc2), .frame_done(fd2),
    .err_width(ew2), .err_height(eh2), .err_data(ed2), .err_lv(el2));

  int total = 0;
  int bad   = 0;
  int done0 = 0;
  int fc_exp = 0;
  int lens[$];

  always @(negedge clk) if (fd0) done0++;

  typedef struct {
    int nl; int short_ln; int bad_ln; int bad_px; int coinc;
    int fw; int fh; int ew; int eh; int ed;
  } vec_t;
  vec_t tbl[7];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  // one frame: line lengths from lens, optional corrupted pixel, optional
  // lv fall coincident with fv fall on the last line
  task automatic send_frame(input int coinc, input int bad_ln, input int bad_px);
    bit hit;
    fv = 1'b1; lv = 1'b0; tick(); tick();
    for (int i = 0; i < lens.size(); i++) begin
      for (int p = 0; p < lens[i]; p++) begin
        hit  = (i == bad_ln) && (p == bad_px);
        lv   = 1'b1;
        data = 10'((p + (hit ? 1 : 0)) % 1024);
        tick();
        if (hit) chk("err_data_next", ed0, 1);
      end
      if (i == lens.size() - 1 && coinc != 0) begin
        lv = 1'b0; fv = 1'b0; tick();
      end else begin
        lv = 1'b0; tick(); tick();
      end
    end
    if (coinc == 0) begin fv = 1'b0; tick(); end
    data = '0; tick(); tick();
  endtask

  task automatic nominal_lens();
    lens.delete();
    for (int i = 0; i < 6; i++) lens.push_back(20);
  endtask

  initial begin
    int d0;
    bit m_ew, m_eh, m_ed;
    rstn = 1'b0; fv = 1'b1; lv = 1'b1; data = 10'd5; clr_err = 1'b0;
    tbl[0] = '{6, -1, -1, -1, 0, 20, 6, 0, 0, 0};
    tbl[1] = '{6,  5, -1, -1, 0, 19, 6, 1, 0, 0};
    tbl[2] = '{5, -1, -1, -1, 0, 20, 5, 0, 1, 0};
    tbl[3] = '{5,  2, -1, -1, 0, 20, 5, 1, 1, 0};
    tbl[4] = '{6, -1,  1,  7, 0, 20, 6, 0, 0, 1};
    tbl[5] = '{6, -1, -1, -1, 1, 20, 6, 0, 0, 0};
    tbl[6] = '{7, -1, -1, -1, 0, 20, 7, 0, 1, 0};

    // reset state while the stream is mid-frame
    tick(); tick();
    chk("rst_fw", fw0, 0); chk("rst_fh", fh0, 0); chk("rst_fc", fc0, 0);
    chk("rst_fd", fd0, 0); chk("rst_ew", ew0, 0); chk("rst_eh", eh0, 0);
    chk("rst_ed", ed0, 0); chk("rst_el", el0, 0);

    // release inside a frame: the partial frame must be ignored
    lv = 1'b0; rstn = 1'b1; tick();
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 13; p++) begin lv = 1'b1; data = 10'(p + 3); tick(); end
      lv = 1'b0; tick();
    end
    fv = 1'b0; tick(); tick();
    chk("partial_fc", fc0, 0); chk("partial_done", done0, 0);
    chk("partial_ew", ew0, 0); chk("partial_ed", ed0, 0);
    nominal_lens(); send_frame(0, -1, -1); fc_exp = 1;
    chk("nom_fc", fc0, 1); chk("nom_fw", fw0, 20); chk("nom_fh", fh0, 6);
    chk("nom_done", done0, 1);
    chk("nom_err", {28'd0, ew0, eh0, ed0, el0}, 0);

    // table of frame shapes
    for (int k = 0; k < 7; k++) begin
      clr_pulse();
      chk("clr_flags", {28'd0, ew0, eh0, ed0, el0}, 0);
      lens.delete();
      for (int i = 0; i < tbl[k].nl; i++) lens.push_back(i == tbl[k].short_ln ? 19 : 20);
      d0 = done0;
      send_frame(tbl[k].coinc, tbl[k].bad_ln, tbl[k].bad_px);
      fc_exp++;
      chk($sformatf("t%0d_fw", k), fw0, tbl[k].fw);
      chk($sformatf("t%0d_fh", k), fh0, tbl[k].fh);
      chk($sformatf("t%0d_fc", k), fc0, fc_exp);
      chk($sformatf("t%0d_ew", k), ew0, tbl[k].ew);
      chk($sformatf("t%0d_eh", k), eh0, tbl[k].eh);
      chk($sformatf("t%0d_ed", k), ed0, tbl[k].ed);
      chk($sformatf("t%0d_ed_nochk", k), ed2, 0);
      chk($sformatf("t%0d_ew_nochk", k), ew2, tbl[k].ew);
      chk($sformatf("t%0d_done", k), done0 - d0, 1);
    end

    // lv outside fv for 3 cycles, then clear coincident with a new event
    clr_pulse();
    fv = 1'b0; lv = 1'b1;
    tick(); tick(); tick();
    lv = 1'b0; tick();
    chk("errlv_set", el0, 1);
    lv = 1'b1; clr_err = 1'b1; tick();
    lv = 1'b0; clr_err = 1'b0;
    chk("errlv_clr_coinc", el0, 1);
    clr_pulse();
    chk("errlv_cleared", el0, 0);
    nominal_lens(); send_frame(0, -1, -1); fc_exp++;
    chk("after_lv_fw", fw0, 20); chk("after_lv_ew", ew0, 0);
    chk("after_lv_el", el0, 0);

    // reset mid-frame: no done pulse, resync via SYNC
    fv = 1'b1; tick(); tick();
    for (int p = 0; p < 20; p++) begin lv = 1'b1; data = 10'(p); tick(); end
    lv = 1'b0; tick();
    d0 = done0;
    rstn = 1'b0; tick(); rstn = 1'b1;
    chk("midrst_fc", fc0, 0); chk("midrst_fw", fw0, 0);
    for (int p = 0; p < 20; p++) begin lv = 1'b1; data = 10'(p); tick(); end
    lv = 1'b0; tick(); fv = 1'b0; tick(); tick();
    chk("midrst_done", done0 - d0, 0); chk("midrst_fc2", fc0, 0);
    nominal_lens(); send_frame(0, -1, -1); fc_exp = 1;
    chk("resync_fc", fc0, 1); chk("resync_fh", fh0, 6);

    // long lines: data ramp wraps 1023 -> 0
    clr_pulse();
    lens.delete(); lens.push_back(1030); lens.push_back(1030);
    send_frame(0, -1, -1); fc_exp++;
    chk("wrap_fw", fw1, 1030); chk("wrap_fh", fh1, 2);
    chk("wrap_ed", ed1, 0); chk("wrap_ew", ew1, 0); chk("wrap_eh", eh1, 0);

    // randomized frames against a frame-level model
    clr_pulse();
    m_ew = 0; m_eh = 0; m_ed = 0;
    for (int f = 0; f < 10; f++) begin
      int nl, bl, bp, co;
      if ($urandom_range(0, 2) == 0) begin
        clr_pulse(); m_ew = 0; m_eh = 0; m_ed = 0;
      end
      nl = $urandom_range(5, 7);
      lens.delete();
      for (int i = 0; i < nl; i++)
        lens.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(18, 22) : 20);
      bl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nl - 1) : -1;
      bp = $urandom_range(0, 17);
      co = $urandom_range(0, 1);
      d0 = done0;
      send_frame(co, bl, bp);
      fc_exp++;
      foreach (lens[i]) if (lens[i] != 20) m_ew = 1;
      if (nl != 6) m_eh = 1;
      if (bl >= 0) m_ed = 1;
      chk($sformatf("r%0d_fw", f), fw0, lens[lens.size() - 1]);
      chk($sformatf("r%0d_fh", f), fh0, nl);
      chk($sformatf("r%0d_fc", f), fc0, fc_exp);
      chk($sformatf("r%0d_ew", f), ew0, m_ew);
      chk($sformatf("r%0d_eh", f), eh0, m_eh);
      chk($sformatf("r%0d_ed", f), ed0, m_ed);
      chk($sformatf("r%0d_ed_nochk", f), ed2, 0);
      chk($sformatf("r%0d_el", f), el0, 0);
      chk($sformatf("r%0d_done", f), done0 - d0, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
